// File: rtl/ctr_seq_ctrl.sv
// ctr_seq_ctrl: command-driven sequencer for a WIDTH-bit up/down counter
// with terminal-count pulse, one-shot or auto-reload, pause and stop.
module ctr_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_down,
    input  logic             cfg_auto,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d;
    logic             down_q, down_d, auto_q, auto_d, tc_q, tc_d;
    logic             is_start, is_pause, is_stop;
    logic [WIDTH-1:0] start_val, term_val;

    assign cmd_ready = state_q != LOAD;
    assign is_start  = cmd_valid & cmd_ready & (cmd_op == 2'b01);
    assign is_pause  = cmd_valid & cmd_ready & (cmd_op == 2'b10);
    assign is_stop   = cmd_valid & cmd_ready & (cmd_op == 2'b11);
    assign start_val = down_q ? limit_q : '0;
    assign term_val  = down_q ? '0 : limit_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        down_d  = down_q;
        auto_d  = auto_q;
        tc_d    = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (is_start) begin
                    {limit_d, down_d, auto_d} = {cfg_limit, cfg_down, cfg_auto};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = start_val;
                state_d = RUN;
            end
            RUN: begin
                // Accepted STOP/PAUSE take priority over a same-cycle tick
                if (is_stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (is_pause) begin
                    state_d = PAUSE;
                end else if (cnt_en) begin
                    if (count_q == term_val) begin
                        tc_d    = 1'b1;
                        count_d = auto_q ? start_val : count_q;
                        state_d = auto_q ? RUN : DONE;
                    end else begin
                        count_d = down_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                    end
                end
            end
            PAUSE: begin
                if (is_stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (is_pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (is_stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (is_start) begin
                    {limit_d, down_d, auto_d} = {cfg_limit, cfg_down, cfg_auto};
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            down_q  <= 1'b0;
            auto_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            down_q  <= down_d;
            auto_q  <= auto_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == LOAD) || (state_q == RUN) || (state_q == PAUSE);
    assign done  = state_q == DONE;
endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// tb_ctr_seq_ctrl: table-driven directed check of ctr_seq_ctrl with a few
// hand-written sequences for asynchronous clear and pause/stop corners.
module tb_ctr_seq_ctrl;
    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cfg_limit = 4'd0;
    logic       cfg_down = 1'b0;
    logic       cfg_auto = 1'b0;
    logic       cnt_en = 1'b0;
    logic [3:0] count;
    logic       tc, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    ctr_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .clear_n(clear_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cfg_limit(cfg_limit), .cfg_down(cfg_down), .cfg_auto(cfg_auto),
        .cnt_en(cnt_en), .count(count), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] lim;
        logic       dn, au, en;
        logic [3:0] c;
        logic       t, b, d, r;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] op, input logic [3:0] lim,
                       input logic dn, input logic au, input logic en,
                       input logic [3:0] c, input logic t, input logic b,
                       input logic d, input logic r);
        vecs.push_back('{v, op, lim, dn, au, en, c, t, b, d, r});
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input int idx, input logic [3:0] c, input logic t,
                           input logic b, input logic d, input logic r);
        chk("count", idx, count, c);
        chk("tc", idx, {3'b0, tc}, {3'b0, t});
        chk("busy", idx, {3'b0, busy}, {3'b0, b});
        chk("done", idx, {3'b0, done}, {3'b0, d});
        chk("cmd_ready", idx, {3'b0, cmd_ready}, {3'b0, r});
    endtask

    task automatic step(input int idx, input vec_t s);
        cmd_valid = s.v;
        cmd_op    = s.op;
        cfg_limit = s.lim;
        cfg_down  = s.dn;
        cfg_auto  = s.au;
        cnt_en    = s.en;
        @(posedge clk);
        #1;
        chk_out(idx, s.c, s.t, s.b, s.d, s.r);
    endtask

    initial begin
        // up one-shot, limit 5
        add(1, 2'b01, 4'd5, 0, 0, 1, 4'd0, 0, 1, 0, 0);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) add(0, 2'b00, 4'd0, 0, 0, 1, 4'(i), 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd5, 1, 0, 1, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd5, 0, 0, 1, 1);
        add(1, 2'b11, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        add(1, 2'b10, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        // down auto, limit 3; STOP offered during LOAD is not accepted
        add(1, 2'b01, 4'd3, 1, 1, 0, 4'd0, 0, 1, 0, 0);
        add(1, 2'b11, 4'd0, 0, 0, 1, 4'd3, 0, 1, 0, 1);
        for (int i = 0; i < 12; i++)
            add(0, 2'b00, 4'd0, 0, 0, 1, 4'((i % 4 == 3) ? 3 : 2 - (i % 4)), (i % 4 == 3), 1, 0, 1);
        add(1, 2'b11, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        // up one-shot, limit 9, pause/resume and ignored START
        add(1, 2'b01, 4'd9, 0, 0, 0, 4'd0, 0, 1, 0, 0);
        add(0, 2'b00, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd1, 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, 1);
        add(1, 2'b10, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 2'b00, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, 1);
        add(1, 2'b01, 4'd1, 1, 1, 1, 4'd2, 0, 1, 0, 1);
        add(1, 2'b10, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd3, 0, 1, 0, 1);
        add(1, 2'b01, 4'd1, 1, 1, 1, 4'd4, 0, 1, 0, 1);
        for (int i = 5; i <= 9; i++) add(0, 2'b00, 4'd0, 0, 0, 1, 4'(i), 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd9, 1, 0, 1, 1);
        // START from DONE reloads a new down configuration
        add(1, 2'b01, 4'd2, 1, 0, 1, 4'd9, 0, 1, 0, 0);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, 1);
        add(1, 2'b11, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        // STOP beats a terminal tick, then limit 0 one-shot
        add(1, 2'b01, 4'd4, 0, 0, 0, 4'd0, 0, 1, 0, 0);
        add(0, 2'b00, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) add(0, 2'b00, 4'd0, 0, 0, 1, 4'(i), 0, 1, 0, 1);
        add(1, 2'b11, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        add(1, 2'b01, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 0);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 1);
        add(0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 1, 0, 1, 1);

        #1;
        chk_out(-1, 4'd0, 0, 0, 0, 1);
        #11 clear_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) step(i, vecs[i]);

        // asynchronous clear while running at count 6
        step(100, '{1, 2'b01, 4'd9, 0, 1, 0, 4'd0, 0, 1, 0, 0});
        step(101, '{0, 2'b00, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 1});
        for (int i = 1; i <= 6; i++) step(101 + i, '{0, 2'b00, 4'd0, 0, 0, 1, 4'(i), 0, 1, 0, 1});
        cnt_en = 1'b0;
        #2 clear_n = 1'b0;
        #1 chk_out(110, 4'd0, 0, 0, 0, 1);
        #2 clear_n = 1'b1;
        step(111, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1});
        step(112, '{1, 2'b01, 4'd2, 1, 0, 1, 4'd0, 0, 1, 0, 0});
        step(113, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, 1});
        step(114, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd1, 0, 1, 0, 1});
        step(115, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 1});
        step(116, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 1, 0, 1, 1});
        // STOP from PAUSE clears the count
        step(120, '{1, 2'b01, 4'd3, 0, 0, 0, 4'd0, 0, 1, 0, 0});
        step(121, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 1});
        step(122, '{0, 2'b00, 4'd0, 0, 0, 1, 4'd1, 0, 1, 0, 1});
        step(123, '{1, 2'b10, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0, 1});
        step(124, '{1, 2'b01, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0, 1});
        step(125, '{1, 2'b11, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctr_seq_ctrl.md
Name: ctr_seq_ctrl

Overview:
Sequencing controller for the structural synchronous counter datapath built from dff_R_asyn cells. It accepts start/pause/stop commands over a valid/ready handshake and latches a terminal value and count direction. It then steps the counter on an external enable tick, flags terminal count, and either stops (one-shot) or reloads (auto mode). It sits between the host-side control logic and the counter register bank.

Parameters:
WIDTH, 4, counter width in bits; also sets the width of cfg_limit and count.

Ports:
clk  input  1  system clock; all state changes on the rising edge
clear_n  input  1  asynchronous reset, active-low; forces the reset state immediately
cmd_valid  input  1  a command is present on cmd_op
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  command: 00 NOP, 01 START, 10 PAUSE/RESUME, 11 STOP
cfg_limit  input  WIDTH  terminal value; sampled only when START is accepted
cfg_down  input  1  1 = count down from limit to 0; 0 = count up from 0 to limit
cfg_auto  input  1  1 = reload on terminal count; 0 = one-shot
cnt_en  input  1  count tick; one step per cycle while high in RUN
count  output  WIDTH  current counter value (registered)
tc  output  1  terminal-count pulse, one cycle wide (registered)
busy  output  1  high in LOAD, RUN and PAUSE
done  output  1  high in DONE

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state IDLE; count=0, tc=0, busy=0, done=0, cmd_ready=1.
  - Latched limit, down and auto bits are all cleared.
  - Applies immediately mid-operation; the first active edge after release runs from IDLE.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_ready=0 only in LOAD; it is 1 in every other state.
  - NOP, or a command with no defined effect in the current state, is accepted and ignored.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - START latches cfg_limit, cfg_down and cfg_auto, then goes to LOAD.
  - PAUSE and STOP are ignored; count holds 0.
- LOAD (exactly 1 cycle):
  - count <= latched_down ? latched_limit : 0.
  - Next state is RUN; cnt_en is ignored.
- RUN:
  - Terminal value is 0 when counting down and latched_limit when counting up.
  - On cnt_en with count != terminal: count steps ±1 on the next edge.
  - On cnt_en with count == terminal: tc=1 on the next cycle only.
    - Auto mode: count reloads to its start value and the block stays in RUN.
    - One-shot: go to DONE; count holds the terminal value.
  - One count period is latched_limit+1 enables.
  - latched_limit=0 gives tc on every enable; count stays 0.
- PAUSE:
  - count frozen; cnt_en is ignored.
  - PAUSE/RESUME returns to RUN.
  - START is ignored; STOP goes to IDLE.
- DONE:
  - done=1, busy=0; count holds.
  - START reloads the new configuration and goes to LOAD; done drops the next cycle.
  - STOP goes to IDLE.
- STOP from RUN, PAUSE or DONE: next state IDLE, count <= 0, no tc.
- Simultaneous events in RUN:
  - An accepted STOP or PAUSE in the same cycle as cnt_en wins: no step and no tc.
  - An ignored START does not block the step.
- Configuration inputs are don't-care except in the START-accept cycle.
- Arithmetic:
  - Plain WIDTH-bit; no wrap is possible inside the [0, limit] window.
  - An up-count with limit = 2^WIDTH−1 reaches terminal before any overflow.

Test Plan:
1. WIDTH=4, clear_n pulsed low for 3ns while in RUN with count=6 -> count=0, busy=0, tc=0 immediately; state IDLE after release; next START works normally.
2. Up one-shot, limit=5, START then cnt_en held high:
   - LOAD cycle: count=0, cmd_ready=0.
   - count then steps 0,1,2,3,4,5.
   - tc=1 for exactly 1 cycle after the 6th enable; done=1, busy=0, count holds 5.
3. Down auto, limit=3, cnt_en high for 12 cycles -> count 3,2,1,0,3,2,1,0,3,... with a tc pulse every 4 enables; busy stays 1; done stays 0.
4. Up, limit=9; PAUSE at count=2; 5 cnt_en pulses -> count stays 2. PAUSE/RESUME -> next enable gives 3. START issued during RUN with cfg_limit=1 -> ignored; terminal remains 9.
5. STOP with cmd_valid in the same cycle as cnt_en at count==terminal (limit=4, up) -> no tc, IDLE, count=0. Then START with limit=0, up, one-shot -> tc on the first enable; done=1, count=0.
